// File: rtl/wash_phase_timer.sv
// Phase countdown timer for the wash cycle controller: arms on timed phase codes,
// ticks every PRESCALE clocks and emits a one-cycle stop pulse when the phase expires.
module wash_phase_timer #(
  parameter int unsigned PRESCALE    = 1000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned T_DETERGENT = 30,
  parameter int unsigned T_WASH      = 600,
  parameter int unsigned T_SPIN      = 300
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       phase,
  input  logic             pause,
  output logic             stop,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [2:0]       armed_phase_q, armed_phase_d;
  logic             stop_q, stop_d;
  logic             busy_q, busy_d;

  logic             timed_c;
  logic [CNT_W-1:0] t_load_c;
  logic             count_en_c;

  // Phase code to tick budget; 000 is untimed, so it doubles as "nothing armed".
  always_comb begin
    timed_c  = 1'b1;
    t_load_c = '0;
    case (phase)
      3'b010:  t_load_c = CNT_W'(T_DETERGENT);
      3'b011:  t_load_c = CNT_W'(T_WASH);
      3'b101:  t_load_c = CNT_W'(T_SPIN);
      default: timed_c  = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    remaining_d   = remaining_q;
    armed_phase_d = armed_phase_q;
    stop_d        = 1'b0;
    busy_d        = busy_q;
    count_en_c    = 1'b0;

    if (!start || !timed_c) begin
      state_d       = S_IDLE;
      presc_d       = '0;
      remaining_d   = '0;
      armed_phase_d = 3'b000;
      busy_d        = 1'b0;
    end else if (phase != armed_phase_q) begin
      state_d       = S_RUN;
      presc_d       = '0;
      remaining_d   = t_load_c;
      armed_phase_d = phase;
      busy_d        = 1'b1;
    end else begin
      case (state_q)
        S_RUN: begin
          if (pause) state_d = S_PAUSED;
          else       count_en_c = 1'b1;
        end
        S_PAUSED: begin
          // The resume edge counts, so a pause of N cycles delays stop by exactly N.
          if (!pause) begin
            state_d    = S_RUN;
            count_en_c = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (count_en_c) begin
      if (remaining_q == '0 ||
          (presc_q == PRESC_MAX && remaining_q == CNT_W'(1))) begin
        state_d     = S_DONE;
        presc_d     = '0;
        remaining_d = '0;
        stop_d      = 1'b1;
        busy_d      = 1'b0;
      end else if (presc_q == PRESC_MAX) begin
        presc_d     = '0;
        remaining_d = remaining_q - CNT_W'(1);
      end else begin
        presc_d     = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      presc_q       <= '0;
      remaining_q   <= '0;
      armed_phase_q <= 3'b000;
      stop_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      remaining_q   <= remaining_d;
      armed_phase_q <= armed_phase_d;
      stop_q        <= stop_d;
      busy_q        <= busy_d;
    end
  end

  assign stop      = stop_q;
  assign busy      = busy_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Self-checking bench for wash_phase_timer: directed scenarios plus randomized
// stimulus against an elapsed-cycle reference model.
module tb_wash_phase_timer;

  localparam int unsigned P  = 4;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    phase = 3'b000;
  logic          pause = 1'b0;
  logic          stop;
  logic          busy;
  logic [CW-1:0] remaining;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remaining = budget minus whole ticks elapsed while counting.
  logic [2:0]    m_armed;
  bit            m_active;
  int            m_t;
  int            m_run;
  logic          m_stop;
  logic          m_busy;
  logic [CW-1:0] m_rem;

  wash_phase_timer #(
    .PRESCALE(P), .CNT_W(CW), .T_DETERGENT(2), .T_WASH(3), .T_SPIN(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .phase(phase), .pause(pause),
    .stop(stop), .busy(busy), .remaining(remaining)
  );

  always #5 clk = ~clk;

  function automatic int t_for(input logic [2:0] p);
    case (p)
      3'b010:  return 2;
      3'b011:  return 3;
      3'b101:  return 1;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_armed = 3'b000; m_active = 0; m_t = 0; m_run = 0;
    m_stop = 1'b0; m_busy = 1'b0; m_rem = '0;
  endtask

  task automatic model_step();
    m_stop = 1'b0;
    if (!start || t_for(phase) < 0) begin
      m_armed = 3'b000; m_active = 0; m_rem = '0;
    end else if (phase != m_armed) begin
      m_armed = phase; m_t = t_for(phase); m_run = 0; m_active = 1;
      m_rem = CW'(m_t);
    end else if (m_active && !pause) begin
      m_run++;
      if (m_t == 0 || m_run == m_t * P) begin
        m_stop = 1'b1; m_active = 0; m_rem = '0;
      end else begin
        m_rem = CW'(m_t - m_run / P);
      end
    end
    m_busy = m_active;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic go_idle();
    start = 1'b0; pause = 1'b0; phase = 3'b000;
    cycle();
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (stop !== 1'b0 || busy !== 1'b0 || remaining !== '0) begin
      n_bad++;
      $display("FAIL reset_state: stop=%b busy=%b rem=%0d required 0/0/0", stop, busy, remaining);
    end
    start = 1'b1; phase = 3'b010;
    cycle(); cycle();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold: busy=%b required 0", busy);
    end
    rst = 1'b0; model_reset();
    start = 1'b1; phase = 3'b000;
    cycle();
    start = 1'b0; phase = 3'b010;
    cycle();
    n_cmp++;
    if (busy !== 1'b0 || remaining !== '0) begin
      n_bad++;
      $display("FAIL no_arm_without_start: busy=%b rem=%0d required 0/0", busy, remaining);
    end
  endtask

  task automatic test_detergent();
    go_idle();
    start = 1'b1; phase = 3'b010;
    cycle();
    n_cmp++;
    if (busy !== 1'b1 || remaining !== 16'd2 || stop !== 1'b0) begin
      n_bad++;
      $display("FAIL det_arm: busy=%b rem=%0d stop=%b required 1/2/0", busy, remaining, stop);
    end
    for (int k = 1; k < 8; k++) begin
      cycle();
      n_cmp++;
      if (stop !== 1'b0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL det_running@%0d: stop=%b busy=%b required 0/1", k, stop, busy);
      end
    end
    cycle();
    n_cmp++;
    if (stop !== 1'b1 || busy !== 1'b0 || remaining !== '0) begin
      n_bad++;
      $display("FAIL det_stop@8: stop=%b busy=%b rem=%0d required 1/0/0", stop, busy, remaining);
    end
    cycle();
    n_cmp++;
    if (stop !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL det_pulse_width: stop=%b busy=%b required 0/0", stop, busy);
    end
  endtask

  task automatic test_pause();
    logic [CW-1:0] held;
    int c;
    go_idle();
    start = 1'b1; phase = 3'b011;
    cycle();
    c = 0;
    cycle(); cycle(); c = 2;
    held = remaining;
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle(); c++;
      n_cmp++;
      if (remaining !== held || busy !== 1'b1 || stop !== 1'b0) begin
        n_bad++;
        $display("FAIL pause_frozen@%0d: rem=%0d busy=%b stop=%b required %0d/1/0", k, remaining, busy, stop, held);
      end
    end
    pause = 1'b0;
    while (stop !== 1'b1 && c < 40) begin
      cycle(); c++;
    end
    n_cmp++;
    if (c !== 17 || stop !== 1'b1) begin
      n_bad++;
      $display("FAIL pause_stop_time: stop at %0d (stop=%b) required 17", c, stop);
    end
  endtask

  task automatic test_phase_change();
    go_idle();
    start = 1'b1; phase = 3'b011;
    cycle();
    for (int k = 0; k < 6; k++) begin
      cycle();
      n_cmp++;
      if (stop !== 1'b0) begin
        n_bad++;
        $display("FAIL wash_no_stop@%0d: stop=%b required 0", k, stop);
      end
    end
    phase = 3'b101;
    cycle();
    n_cmp++;
    if (remaining !== 16'd1 || busy !== 1'b1 || stop !== 1'b0) begin
      n_bad++;
      $display("FAIL change_rearm: rem=%0d busy=%b stop=%b required 1/1/0", remaining, busy, stop);
    end
    for (int k = 1; k <= 4; k++) begin
      cycle();
      n_cmp++;
      if (stop !== (k == 4)) begin
        n_bad++;
        $display("FAIL spin_stop@%0d: stop=%b required %0d", k, stop, (k == 4));
      end
    end
  endtask

  task automatic test_abort();
    go_idle();
    start = 1'b1; phase = 3'b010;
    cycle();
    repeat (3) cycle();
    start = 1'b0;
    cycle();
    n_cmp++;
    if (busy !== 1'b0 || remaining !== '0 || stop !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_clear: busy=%b rem=%0d stop=%b required 0/0/0", busy, remaining, stop);
    end
    for (int k = 0; k < 12; k++) begin
      cycle();
      n_cmp++;
      if (stop !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_quiet@%0d: stop=%b busy=%b required 0/0", k, stop, busy);
      end
    end
  endtask

  task automatic test_hold();
    int pulses, first_at, c;
    go_idle();
    start = 1'b1; phase = 3'b010;
    cycle();
    pulses = 0; first_at = -1;
    for (int i = 1; i <= 28; i++) begin
      cycle();
      if (stop === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = i;
      end
    end
    n_cmp++;
    if (pulses !== 1 || first_at !== 8) begin
      n_bad++;
      $display("FAIL hold_single_pulse: pulses=%0d first=%0d required 1/8", pulses, first_at);
    end
    phase = 3'b000;
    cycle();
    phase = 3'b010;
    cycle();
    n_cmp++;
    if (busy !== 1'b1 || remaining !== 16'd2) begin
      n_bad++;
      $display("FAIL hold_rearm: busy=%b rem=%0d required 1/2", busy, remaining);
    end
    c = 0;
    while (stop !== 1'b1 && c < 40) begin
      cycle(); c++;
    end
    n_cmp++;
    if (c !== 8) begin
      n_bad++;
      $display("FAIL hold_second_stop: stop after %0d required 8", c);
    end
  endtask

  task automatic test_rst_async();
    go_idle();
    start = 1'b1; phase = 3'b011;
    cycle();
    repeat (5) cycle();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || stop !== 1'b0 || remaining !== '0) begin
      n_bad++;
      $display("FAIL rst_async: busy=%b stop=%b rem=%0d required 0/0/0", busy, stop, remaining);
    end
    model_reset();
    #2 rst = 1'b0;
    cycle();
    n_cmp++;
    if (busy !== 1'b1 || remaining !== 16'd3) begin
      n_bad++;
      $display("FAIL rst_rearm: busy=%b rem=%0d required 1/3", busy, remaining);
    end
  endtask

  task automatic test_random();
    int bad_here;
    bad_here = 0;
    start = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 39) == 0) start = 1'b0;
      else if (!start && $urandom_range(0, 2) == 0) start = 1'b1;
      if ($urandom_range(0, 9) == 0) phase = 3'($urandom_range(0, 6));
      if ($urandom_range(0, 5) == 0) pause = ~pause;
      cycle();
      n_cmp++;
      if (stop !== m_stop || busy !== m_busy || remaining !== m_rem) begin
        n_bad++;
        if (bad_here < 10)
          $display("FAIL random@%0d: stop=%b busy=%b rem=%0d required %b/%b/%0d",
                   k, stop, busy, remaining, m_stop, m_busy, m_rem);
        bad_here++;
      end
    end
    pause = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_detergent();
    test_pause();
    test_phase_change();
    test_abort();
    test_hold();
    test_rst_async();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
